// File: rtl/decode_instruction_pkg.sv
// Shared widths, opcode constants and instruction field positions for the decode stage.
// Optional write bypass is selected with DECODE_WB_BYPASS_EN.
package decode_instruction_pkg;
  localparam int ADDR     = 32;
  localparam int W_INST   = 32;
  localparam int W_OPC    = 7;
  localparam int W_OPR    = 32;
  localparam int W_RD     = 5;
  localparam int W_IMM    = 16;
  localparam int NUM_REGS = 32;

  localparam logic [W_OPC-1:0] OPC_CMP = 7'h04;
  localparam logic [W_OPC-1:0] OPC_LD  = 7'h18;
  localparam logic [W_OPC-1:0] OPC_ST  = 7'h19;
  localparam logic [W_OPC-1:0] OPC_J   = 7'h1C;
  localparam logic [W_OPC-1:0] OPC_JA  = 7'h1D;
  localparam logic [W_OPC-1:0] OPC_NOP = 7'h1E;
  localparam logic [W_OPC-1:0] OPC_HLT = 7'h1F;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 25;
  localparam int R0_MSB      = 24;
  localparam int R0_LSB      = 20;
  localparam int IMMF_BIT    = 19;
  localparam int IMMSIGN_BIT = 18;
  localparam int RSV_MSB     = 17;
  localparam int RSV_LSB     = 16;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 0;
  localparam int R1_MSB      = 4;
  localparam int R1_LSB      = 0;

  // Registered decode presented to execute.
  typedef struct packed {
    logic             v;
    logic [ADDR-1:0]  pc;
    logic [W_OPC-1:0] opc;
    logic             immf;
    logic             immsign;
    logic [W_IMM-1:0] imm;
    logic             stf;
    logic [W_OPR-1:0] opr0;
    logic [W_OPR-1:0] opr1;
    logic             wb;
    logic [W_RD-1:0]  wb_r;
  } dec_out_t;

  function automatic logic opc_wb(input logic [W_OPC-1:0] opc);
    return opc inside {[7'h00:7'h03], [7'h05:7'h0A], 7'h0C, 7'h0D,
                       [7'h10:7'h13], 7'h16, 7'h17, OPC_LD};
  endfunction
endpackage

// File: rtl/decode_instruction_if.sv
// Decode <-> execute bundle: decoded instruction forward, stall/branch/writeback back.
interface decode_instruction_if;
  import decode_instruction_pkg::*;
  logic             v_o;
  logic [ADDR-1:0]  pc_o;
  logic [W_OPC-1:0] opecode_o;
  logic             immf_o;
  logic             immsign_o;
  logic [W_IMM-1:0] imm_o;
  logic             stf_o;
  logic [W_OPR-1:0] opr0_o;
  logic [W_OPR-1:0] opr1_o;
  logic             wb_o;
  logic [W_RD-1:0]  wb_r_o;
  logic             stall_i;
  logic             branch_i;
  logic             wb_i;
  logic [W_RD-1:0]  wb_r_i;
  logic [W_OPR-1:0] result_i;

  modport master (
    output v_o, pc_o, opecode_o, immf_o, immsign_o, imm_o, stf_o,
           opr0_o, opr1_o, wb_o, wb_r_o,
    input  stall_i, branch_i, wb_i, wb_r_i, result_i
  );
  modport slave (
    input  v_o, pc_o, opecode_o, immf_o, immsign_o, imm_o, stf_o,
           opr0_o, opr1_o, wb_o, wb_r_o,
    output stall_i, branch_i, wb_i, wb_r_i, result_i
  );
endinterface

// File: rtl/decode_instruction_register_file.sv
// 32-entry register file, two async read ports, one write port, synchronous clear.
// DECODE_WB_BYPASS_EN forwards the in-flight write to the read ports.
module register_file
  import decode_instruction_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [W_RD-1:0]  ra0_i,
  input  logic [W_RD-1:0]  ra1_i,
  output logic [W_OPR-1:0] rd0_o,
  output logic [W_OPR-1:0] rd1_o,
  input  logic             we_i,
  input  logic [W_RD-1:0]  wa_i,
  input  logic [W_OPR-1:0] wd_i
);
  logic [NUM_REGS-1:0][W_OPR-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (!reset)    mem_q <= '0;
    else if (we_i) mem_q[wa_i] <= wd_i;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd0_o = (we_i && wa_i == ra0_i) ? wd_i : mem_q[ra0_i];
  assign rd1_o = (we_i && wa_i == ra1_i) ? wd_i : mem_q[ra1_i];
`else
  assign rd0_o = mem_q[ra0_i];
  assign rd1_o = mem_q[ra1_i];
`endif
endmodule

// File: rtl/decode_instruction.sv
// Decode/operand-fetch stage: field split, register read, RAW bubble, branch squash.
// DECODE_WB_BYPASS_EN selects write bypass; without it writeback-in-flight also stalls.
module decode_instruction
  import decode_instruction_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              v_i,
  output logic              stall_o,
  input  logic [ADDR-1:0]   pc_i,
  input  logic [W_INST-1:0] inst_i,
  decode_instruction_if.master dec
);
  logic [W_OPC-1:0] opc;
  logic [W_RD-1:0]  r0, r1;
  logic             immf;
  logic [W_OPR-1:0] rd0, rd1;
  logic             ex_haz, wb_haz, hazard;
  dec_out_t         out_d, out_q;
  logic [1:0]       unused_rsv;

  assign opc        = inst_i[OPC_MSB:OPC_LSB];
  assign r0         = inst_i[R0_MSB:R0_LSB];
  assign r1         = inst_i[R1_MSB:R1_LSB];
  assign immf       = inst_i[IMMF_BIT];
  assign unused_rsv = inst_i[RSV_MSB:RSV_LSB];

  register_file u_rf (
    .clk   (clk),
    .reset (reset),
    .ra0_i (r0),
    .ra1_i (r1),
    .rd0_o (rd0),
    .rd1_o (rd1),
    .we_i  (dec.wb_i),
    .wa_i  (dec.wb_r_i),
    .wd_i  (dec.result_i)
  );

  assign ex_haz = out_q.v && out_q.wb &&
                  (out_q.wb_r == r0 || (!immf && out_q.wb_r == r1));
`ifdef DECODE_WB_BYPASS_EN
  assign wb_haz = 1'b0;
`else
  // Without forwarding, a write landing this edge is not yet readable.
  assign wb_haz = dec.wb_i && (dec.wb_r_i == r0 || (!immf && dec.wb_r_i == r1));
`endif
  assign hazard  = v_i && (ex_haz || wb_haz);
  assign stall_o = dec.stall_i || (hazard && !dec.branch_i);

  // Fields load whenever not stalled; they are only meaningful when v is set.
  always_comb begin
    out_d = out_q;
    if (!dec.stall_i) begin
      out_d.v       = v_i && !hazard && !dec.branch_i;
      out_d.pc      = pc_i;
      out_d.opc     = opc;
      out_d.immf    = immf;
      out_d.immsign = inst_i[IMMSIGN_BIT];
      out_d.imm     = inst_i[IMM_MSB:IMM_LSB];
      out_d.stf     = (opc == OPC_ST);
      out_d.opr0    = rd0;
      out_d.opr1    = rd1;
      out_d.wb      = opc_wb(opc);
      out_d.wb_r    = r0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign dec.v_o       = out_q.v;
  assign dec.pc_o      = out_q.pc;
  assign dec.opecode_o = out_q.opc;
  assign dec.immf_o    = out_q.immf;
  assign dec.immsign_o = out_q.immsign;
  assign dec.imm_o     = out_q.imm;
  assign dec.stf_o     = out_q.stf;
  assign dec.opr0_o    = out_q.opr0;
  assign dec.opr1_o    = out_q.opr1;
  assign dec.wb_o      = out_q.wb;
  assign dec.wb_r_o    = out_q.wb_r;
endmodule
